// File: rtl/mul_div_if.sv
// Multiply/divide unit bus: EX-stage operation request, stall/busy status
// and the architectural HI/LO read ports.
interface mul_div_if;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        ext_stall;
    logic        cancel;
    logic        md_stall;
    logic        md_busy;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    // Pipeline side: issues the operation and observes stall/HI/LO
    modport master (
        output md_op, src_a, src_b, ext_stall, cancel,
        input  md_stall, md_busy, hi_o, lo_o
    );

    // Unit side
    modport slave (
        input  md_op, src_a, src_b, ext_stall, cancel,
        output md_stall, md_busy, hi_o, lo_o
    );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU finish MUL_CYCLES cycles after entering EX (the product is
// written at the end of the last of those cycles). DIV/DIVU use one setup
// cycle, 32 restoring iterations and a done cycle that writes HI/LO.
// md_stall holds the front of the pipe until the done cycle.
module mul_div_unit #(
    parameter int MUL_CYCLES = 2
) (
    input  logic      clk,
    input  logic      rst,
    mul_div_if.slave  bus
);

    localparam int DIV_CYCLES = 33;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    // The MUL state covers cycles 1..MUL_CYCLES-1; the last of them is the
    // done cycle, so the counter is loaded with MUL_CYCLES-2.
    localparam bit         MUL_SINGLE = (MUL_CYCLES == 1);
    localparam logic [5:0] MUL_LOAD   = 6'((MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0);
    localparam logic [5:0] DIV_LOAD   = 6'(DIV_CYCLES - 1);

    logic [1:0]  r_state;
    logic [5:0]  r_count;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [2:0]  r_op;
    logic [31:0] r_a;        // multiplicand, or dividend/quotient shift register
    logic [31:0] r_b;        // multiplier, or divisor magnitude
    logic [31:0] r_rem;      // partial remainder
    logic        r_neg_q;
    logic        r_neg_r;

    logic        w_idle;
    logic        w_op_mul;
    logic        w_op_div;
    logic        w_start;
    logic        w_active;
    logic        w_counting;
    logic        w_done;
    logic        w_div_signed;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;

    logic        w_mul_sgn;
    logic [31:0] w_mul_a;
    logic [31:0] w_mul_b;
    logic signed [63:0] w_mul_a_ext;
    logic signed [63:0] w_mul_b_ext;
    logic signed [63:0] w_prod;

    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    assign w_idle       = (r_state == S_IDLE);
    assign w_op_mul     = (bus.md_op == OP_MULT) || (bus.md_op == OP_MULTU);
    assign w_op_div     = (bus.md_op == OP_DIV)  || (bus.md_op == OP_DIVU);
    assign w_start      = (w_op_mul || w_op_div) && !bus.cancel && w_idle;
    assign w_active     = (r_state == S_MUL) || (r_state == S_DIV);
    assign w_counting   = w_active && (r_count != 6'd0);
    assign w_done       = w_active && (r_count == 6'd0);
    assign w_div_signed = (bus.md_op == OP_DIV);
    assign w_abs_a      = (w_div_signed && bus.src_a[31]) ? (32'd0 - bus.src_a) : bus.src_a;
    assign w_abs_b      = (w_div_signed && bus.src_b[31]) ? (32'd0 - bus.src_b) : bus.src_b;

    // One multiplier serves both the single-cycle case (live operands in
    // IDLE) and the multi-cycle case (latched operands in MUL).
    assign w_mul_sgn   = w_idle ? (bus.md_op == OP_MULT) : (r_op == OP_MULT);
    assign w_mul_a     = w_idle ? bus.src_a : r_a;
    assign w_mul_b     = w_idle ? bus.src_b : r_b;
    assign w_mul_a_ext = {{32{w_mul_sgn & w_mul_a[31]}}, w_mul_a};
    assign w_mul_b_ext = {{32{w_mul_sgn & w_mul_b[31]}}, w_mul_b};
    assign w_prod      = w_mul_a_ext * w_mul_b_ext;

    // Restoring division step; a zero divisor naturally yields an all-ones
    // quotient and the dividend as remainder.
    assign w_shift   = {r_rem, r_a[31]};
    assign w_diff    = w_shift - {1'b0, r_b};
    assign w_ge      = ~w_diff[32];
    assign w_quo_fix = r_neg_q ? (32'd0 - r_a)   : r_a;
    assign w_rem_fix = r_neg_r ? (32'd0 - r_rem) : r_rem;

    assign bus.md_stall = !rst && !bus.cancel &&
                          ((w_start && (w_op_div || !MUL_SINGLE)) || w_counting);
    assign bus.md_busy  = w_active;
    assign bus.hi_o     = r_hi;
    assign bus.lo_o     = r_lo;

    // Control FSM: sequencing, countdown and HOLD while the pipe is frozen elsewhere
    always_ff @(posedge clk) begin
        if (rst || bus.cancel) begin
            r_state <= S_IDLE;
            r_count <= 6'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        if (w_op_div) begin
                            r_state <= S_DIV;
                            r_count <= DIV_LOAD;
                        end else if (MUL_SINGLE) begin
                            r_state <= bus.ext_stall ? S_HOLD : S_IDLE;
                        end else begin
                            r_state <= S_MUL;
                            r_count <= MUL_LOAD;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (r_count != 6'd0) begin
                        r_count <= r_count - 6'd1;
                    end else begin
                        r_state <= bus.ext_stall ? S_HOLD : S_IDLE;
                    end
                end
                default: begin
                    if (!bus.ext_stall) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Architectural HI/LO: result write on done, MTHI/MTLO in IDLE; cancel blocks both
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (!bus.cancel) begin
            if (w_done && (r_state == S_MUL)) begin
                r_hi <= w_prod[63:32];
                r_lo <= w_prod[31:0];
            end else if (w_done) begin
                r_hi <= w_rem_fix;
                r_lo <= w_quo_fix;
            end else if (w_start && w_op_mul && MUL_SINGLE) begin
                r_hi <= w_prod[63:32];
                r_lo <= w_prod[31:0];
            end else if (w_idle && (bus.md_op == OP_MTHI)) begin
                r_hi <= bus.src_a;
            end else if (w_idle && (bus.md_op == OP_MTLO)) begin
                r_lo <= bus.src_a;
            end
        end
    end

    // Operand latch on start, then one restoring iteration per DIV count
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_op <= bus.md_op;
            if (w_op_div) begin
                r_a     <= w_abs_a;
                r_b     <= w_abs_b;
                r_rem   <= 32'd0;
                r_neg_q <= w_div_signed & (bus.src_a[31] ^ bus.src_b[31]);
                r_neg_r <= w_div_signed & bus.src_a[31];
            end else begin
                r_a <= bus.src_a;
                r_b <= bus.src_b;
            end
        end else if ((r_state == S_DIV) && (r_count != 6'd0)) begin
            r_a   <= {r_a[30:0], w_ge};
            r_rem <= w_ge ? w_diff[31:0] : w_shift[31:0];
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit (MUL_CYCLES = 2): the stimulus pushes
// expected {HI,LO} values, a monitor pops them when the unit finishes an
// operation (md_busy falls) or when HI/LO change outside of that.
module tb_mul_div_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul_div_if bus ();

    mul_div_unit #(.MUL_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic ext, input logic can);
        bus.md_op     = op;
        bus.src_a     = a;
        bus.src_b     = b;
        bus.ext_stall = ext;
        bus.cancel    = can;
    endtask

    // Issue one MULT/DIV op at the current cycle (cycle 0) and hold it in EX
    // while stalled; md_stall expected in cycles 0..nstall-1, busy in 1..nstall.
    task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int nstall, input logic [63:0] exp_res);
        exp_q.push_back(exp_res);
        drive(op, a, b, 1'b0, 1'b0);
        for (int k = 0; k <= nstall; k++) begin
            @(negedge clk);
            chk($sformatf("%s stall c%0d", nm, k), 64'(bus.md_stall), 64'(k < nstall));
            chk($sformatf("%s busy c%0d", nm, k), 64'(bus.md_busy), 64'(k >= 1));
            next_cycle();
        end
        bus.md_op = 3'd0;
        next_cycle();
    endtask

    // Monitor: compares HI/LO against the scoreboard whenever the unit presents a result
    logic        mon_busy;
    logic [31:0] mon_hi;
    logic [31:0] mon_lo;
    always @(negedge clk) begin
        if (rst) begin
            mon_busy = 1'b0;
            mon_hi   = bus.hi_o;
            mon_lo   = bus.lo_o;
        end else begin
            if ((mon_busy && !bus.md_busy) || (bus.hi_o !== mon_hi) || (bus.lo_o !== mon_lo)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected result: got %h%h expected none", bus.hi_o, bus.lo_o);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    if ({bus.hi_o, bus.lo_o} !== e) begin
                        errors++;
                        $display("FAIL hilo: got %h%h expected %h", bus.hi_o, bus.lo_o, e);
                    end
                end
            end
            mon_busy = bus.md_busy;
            mon_hi   = bus.hi_o;
            mon_lo   = bus.lo_o;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with a DIVU presented: no stall while reset is high
        rst = 1'b1;
        drive(3'd4, 32'd5, 32'd1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset stall", 64'(bus.md_stall), 64'd0);
        chk("reset busy", 64'(bus.md_busy), 64'd0);
        chk("reset hi", 64'(bus.hi_o), 64'd0);
        chk("reset lo", 64'(bus.lo_o), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        next_cycle();

        run_op("divu 100/7", 3'd4, 32'd100, 32'd7, 33, {32'd2, 32'd14});
        run_op("div -7/2", 3'd3, 32'hFFFF_FFF9, 32'd2, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op("div 7/-2", 3'd3, 32'd7, 32'hFFFF_FFFE, 33, {32'd1, 32'hFFFF_FFFD});
        run_op("mult -1*2", 3'd1, 32'hFFFF_FFFF, 32'd2, 1, {32'hFFFF_FFFF, 32'hFFFF_FFFE});
        run_op("multu max*max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, {32'hFFFF_FFFE, 32'h0000_0001});

        // DIVU with ext_stall in cycles 33..35: HOLD, no restart, single write
        exp_q.push_back({32'd10, 32'd30});
        drive(3'd4, 32'd1000, 32'd33, 1'b0, 1'b0);
        for (int k = 0; k <= 36; k++) begin
            if (k == 33) bus.ext_stall = 1'b1;
            if (k == 36) bus.ext_stall = 1'b0;
            @(negedge clk);
            chk($sformatf("hold stall c%0d", k), 64'(bus.md_stall), 64'(k < 33));
            chk($sformatf("hold busy c%0d", k), 64'(bus.md_busy), 64'((k >= 1) && (k <= 33)));
            next_cycle();
        end
        run_op("divu 50/0", 3'd4, 32'd50, 32'd0, 33, {32'd50, 32'hFFFF_FFFF});

        // DIV cancelled in cycle 10: HI/LO untouched, IDLE in cycle 11
        exp_q.push_back({32'd50, 32'hFFFF_FFFF});
        drive(3'd3, 32'd77, 32'd5, 1'b0, 1'b0);
        for (int k = 0; k <= 10; k++) begin
            if (k == 10) bus.cancel = 1'b1;
            @(negedge clk);
            chk($sformatf("cancel stall c%0d", k), 64'(bus.md_stall), 64'(k < 10));
            next_cycle();
        end
        drive(3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("cancel busy after", 64'(bus.md_busy), 64'd0);
        chk("cancel stall after", 64'(bus.md_stall), 64'd0);
        next_cycle();

        // MTHI then MTLO back-to-back, never stalling
        exp_q.push_back({32'h1234_5678, 32'hFFFF_FFFF});
        exp_q.push_back({32'h1234_5678, 32'h9ABC_DEF0});
        drive(3'd5, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("mthi stall", 64'(bus.md_stall), 64'd0);
        next_cycle();
        drive(3'd6, 32'h9ABC_DEF0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("mtlo stall", 64'(bus.md_stall), 64'd0);
        next_cycle();
        drive(3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        next_cycle();

        // Cancelled MTLO must not write
        drive(3'd6, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b1);
        next_cycle();
        drive(3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("cancelled mtlo lo", 64'(bus.lo_o), 64'h9ABC_DEF0);
        repeat (3) next_cycle();

        chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
